// File: rtl/event_encoder.sv
// event_encoder: gathers single-cycle event pulses on an N-bit request bus and
// emits them one at a time, lowest index first, as binary indices over a
// valid/ready handshake. Events not yet presented wait in a pending register.
// An event that arrives while the same bit is still pending merges with it and
// is reported as a drop.
module event_encoder #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] pending_o,
    output logic         drop_o,
    output logic [7:0]   drop_cnt_o
);

    logic [N-1:0] pend;
    logic [N-1:0] combined;
    logic [N-1:0] pend_after_pick;
    logic [W-1:0] pick_idx;
    logic         any_event;
    logic         load;
    logic         drop_cond;

    // Merge the new pulses into the pending set. Decide whether the output
    // slot can take a new event this cycle: it is either empty or being
    // consumed. A pulse that hits a bit already pending is lost.
    always_comb begin
        combined  = pend | req_i;
        any_event = |combined;
        load      = !valid_o || ready_i;
        drop_cond = |(req_i & pend);
    end

    // Fixed-priority pick. The loop runs from the top bit downward so the
    // last match, which is the lowest set bit, wins. That bit is then removed
    // from the set that stays pending.
    always_comb begin
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (combined[i]) begin
                pick_idx = W'(i);
            end
        end
        pend_after_pick = combined & ~(N'(1) << pick_idx);
    end

    // Pending set and output slot. When the slot is busy and not consumed,
    // idx_o and valid_o hold, and every new pulse waits in the pending set.
    // When the slot is empty and nothing waits, idx_o keeps its old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend    <= '0;
            valid_o <= 1'b0;
            idx_o   <= '0;
        end else if (load) begin
            if (any_event) begin
                idx_o   <= pick_idx;
                valid_o <= 1'b1;
                pend    <= pend_after_pick;
            end else begin
                valid_o <= 1'b0;
                pend    <= '0;
            end
        end else begin
            pend <= combined;
        end
    end

    // Drop reporting. The flag follows the offending cycle by one clock, and
    // the counter stops at 255 so that a long storm of drops cannot wrap it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_o     <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else begin
            drop_o <= drop_cond;
            if (drop_cond && (drop_cnt_o != 8'hFF)) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

    assign pending_o = pend;

endmodule

// File: doc/event_encoder.md
# event_encoder

Sequential N-to-log2(N) priority encoder, the inverse of the team's one-hot decoder: it collects single-cycle event pulses on an N-bit request bus and emits them one at a time as binary indices over a valid/ready handshake. Requests that cannot be served immediately are held in a pending register. The block sits between event sources, such as interrupt lines or decoded strobes, and any consumer that wants a compact index stream.

## Interface

- N, default 4: number of request lines; legal range 2..32.
- W, derived as $clog2(N): index width; not overridable.
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- req_i, input, N: event pulses; any number of bits may be high in the same cycle.
- idx_o, output, W: encoded index of the event being presented.
- valid_o, output, 1: idx_o holds a valid event.
- ready_i, input, 1: consumer accepts idx_o this cycle when valid_o is also high.
- pending_o, output, N: events captured but not yet presented.
- drop_o, output, 1: one-cycle pulse; at least one request was lost in the previous cycle.
- drop_cnt_o, output, 8: saturating count of cycles in which drop_o pulsed.

## Operation

- State is held in four registers: pending P[N-1:0], output register {valid_o, idx_o}, drop_o and drop_cnt_o.
- Each cycle the block forms C = P | req_i.
- load = !valid_o || ready_i; this means the output slot is empty or is being consumed this cycle.
- If load is high and C != 0:
  - idx_o <= index of the lowest set bit of C (fixed priority, bit 0 highest).
  - valid_o <= 1.
  - P <= C with that bit cleared.
- If load is high and C == 0: valid_o <= 0, P <= 0, and idx_o holds its value.
- If load is low: valid_o, idx_o hold; P <= C.
- Drop condition: any i with req_i[i] && P[i]. Requests merge, so an event already pending is lost.
- A request on bit k while idx_o == k is presented is not a drop. It is captured into P[k] and presented again later.
- drop_o <= drop condition, registered. drop_cnt_o increments when the drop condition is high and saturates at 255.
- pending_o = P, driven combinationally from the register.
- Stability: while valid_o && !ready_i, idx_o must not change.
- Reset with rst_n low at a rising edge:
  - P = 0, valid_o = 0, idx_o = 0, drop_o = 0, drop_cnt_o = 0.
  - req_i in the same cycle is ignored.
- Reset has priority over every other event, including mid-handshake. A presented but unaccepted event is discarded.

## Timing

- Latency: req_i bit sampled at edge t with an empty output slot gives valid_o high and idx_o correct immediately after edge t. The event is visible in the cycle following the request.
- Throughput: one index per cycle while ready_i is held high and events are pending.
- Back-to-back: with valid_o && ready_i at edge t, the next event from C loads at the same edge. There is no bubble.
- Simultaneous requests are presented in ascending index order on consecutive accepted cycles.
- ready_i with valid_o low has no effect.
- drop_o and the drop_cnt_o update appear one cycle after the offending req_i.
- No combinational path from req_i or ready_i to any output.

## Test plan

Each scenario is a bench stimulus with its required response, with N = 4.

- **Reset:** hold rst_n = 0 for 2 cycles with req_i = 4'b1111.
  - Outputs after reset: valid_o = 0, idx_o = 0, pending_o = 0, drop_cnt_o = 0.
  - After release: pending_o and valid_o stay 0 until a new req_i arrives.
- **Single events:** ready_i = 1; pulse req_i = 1<<k for k = 0..3, one per 3 cycles.
  - Each pulse gives valid_o = 1 and idx_o = k for exactly one cycle, starting the cycle after the pulse.
- **Burst ordering:** ready_i = 1; pulse req_i = 4'b1011 for one cycle.
  - idx_o = 0, 1, 3 on three consecutive cycles with valid_o high.
  - pending_o = 4'b1010, then 4'b1000, then 0.
  - valid_o falls on the 4th cycle.
- **Backpressure:** ready_i = 0; pulse req_i = 4'b0110.
  - idx_o = 1, valid_o = 1 held stable for 5 cycles; pending_o = 4'b0100.
  - Raise ready_i: next cycle idx_o = 2, then valid_o = 0.
- **Drop and saturation:** ready_i = 0; pulse req_i = 4'b0101, then 4'b0100 one cycle later.
  - drop_o pulses once; drop_cnt_o = 1.
  - Repeat the duplicate pulse 300 times: drop_cnt_o = 255 and does not wrap.
- **Reset mid-operation:** with valid_o = 1, idx_o = 2, pending_o = 4'b1000, assert rst_n = 0 for one edge.
  - All outputs return to their reset values; the pending event 3 is never presented.
